frac_div_ctrl: RTL

//  Runtime-configurable fractional clock-divider sequencer. Divides clk by M + num/den using a dual-modulus

---
 rtl/frac_div_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/frac_div_ctrl.sv
// Dual-modulus fractional clock-divider sequencer: divides clk by M + num/den.
// Optional ~50% duty output clk_div_sq is built when FDIV_DUTY_EN is defined.
module frac_div_ctrl #(
   parameter int CW = 8,
   parameter int FW = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_int,
   input  logic [FW-1:0] cfg_num,
   input  logic [FW-1:0] cfg_den,
   input  logic          en,
   output logic          clk_div,
   output logic          sel_long,
   output logic          busy,
   output logic          cfg_err
`ifdef FDIV_DUTY_EN
   ,
   output logic          clk_div_sq
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [FW:0]   acc_q, acc_d;
   logic          sel_long_q, sel_long_d;
   logic          clk_div_q;
   logic          cfg_err_q, cfg_err_d;

   logic          act_vld_q, act_vld_d;
   logic [CW-1:0] act_m_q, act_m_d;
   logic [FW-1:0] act_num_q, act_num_d;
   logic [FW-1:0] act_den_q, act_den_d;

   logic          pend_q, pend_d;
   logic [CW-1:0] sh_m_q, sh_m_d;
   logic [FW-1:0] sh_num_q, sh_num_d;
   logic [FW-1:0] sh_den_q, sh_den_d;

   logic          start;
   logic [CW-1:0] eff_m;
   logic [FW-1:0] eff_num;
   logic [FW-1:0] eff_den;
   logic [FW:0]   acc_base;
   logic [FW:0]   sum;
   logic          is_long;
   logic          cfg_legal;

   assign cfg_legal = (cfg_int >= CW'(2)) && (cfg_den != '0) && (cfg_num < cfg_den);
   // acc < den and num < den, so the sum always fits in FW+1 bits
   assign sum       = acc_base + {1'b0, eff_num};
   assign is_long   = (sum >= {1'b0, eff_den});

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      sel_long_d = sel_long_q;
      cfg_err_d  = 1'b0;
      act_vld_d  = act_vld_q;
      act_m_d    = act_m_q;
      act_num_d  = act_num_q;
      act_den_d  = act_den_q;
      pend_d     = pend_q;
      sh_m_d     = sh_m_q;
      sh_num_d   = sh_num_q;
      sh_den_d   = sh_den_q;
      start      = 1'b0;
      eff_m      = act_m_q;
      eff_num    = act_num_q;
      eff_den    = act_den_q;
      acc_base   = acc_q;

      unique case (state_q)
         IDLE: begin
            if (pend_q) begin
               act_vld_d = 1'b1;
               act_m_d   = sh_m_q;
               act_num_d = sh_num_q;
               act_den_d = sh_den_q;
               pend_d    = 1'b0;
               eff_m     = sh_m_q;
               eff_num   = sh_num_q;
               eff_den   = sh_den_q;
            end
            if (en && (act_vld_q || pend_q)) begin
               state_d  = RUN;
               start    = 1'b1;
               acc_base = '0;
            end
         end
         RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!en) begin
               state_d    = IDLE;
               sel_long_d = 1'b0;
               acc_d      = '0;
            end else begin
               // Period boundary: a pending ratio takes over here with a fresh accumulator
               if (pend_q) begin
                  act_m_d   = sh_m_q;
                  act_num_d = sh_num_q;
                  act_den_d = sh_den_q;
                  pend_d    = 1'b0;
                  eff_m     = sh_m_q;
                  eff_num   = sh_num_q;
                  eff_den   = sh_den_q;
                  acc_base  = '0;
               end
               start = 1'b1;
            end
         end
      endcase

      if (start) begin
         sel_long_d = is_long;
         acc_d      = is_long ? (sum - {1'b0, eff_den}) : sum;
         cnt_d      = is_long ? eff_m : (eff_m - 1'b1);
      end

      // cfg_ready is ~pend_q, so a pending shadow is never overwritten
      if (cfg_valid && !pend_q) begin
         if (cfg_legal) begin
            pend_d   = 1'b1;
            sh_m_d   = cfg_int;
            sh_num_d = cfg_num;
            sh_den_d = cfg_den;
         end else begin
            cfg_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         sel_long_q <= 1'b0;
         clk_div_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
         act_vld_q  <= 1'b0;
         act_m_q    <= '0;
         act_num_q  <= '0;
         act_den_q  <= '0;
         pend_q     <= 1'b0;
         sh_m_q     <= '0;
         sh_num_q   <= '0;
         sh_den_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         sel_long_q <= sel_long_d;
         clk_div_q  <= (state_d == RUN) && (cnt_d == '0);
         cfg_err_q  <= cfg_err_d;
         act_vld_q  <= act_vld_d;
         act_m_q    <= act_m_d;
         act_num_q  <= act_num_d;
         act_den_q  <= act_den_d;
         pend_q     <= pend_d;
         sh_m_q     <= sh_m_d;
         sh_num_q   <= sh_num_d;
         sh_den_q   <= sh_den_d;
      end
   end

   assign cfg_ready = ~pend_q;
   assign clk_div   = clk_div_q;
   assign sel_long  = sel_long_q;
   assign busy      = (state_q == RUN);
   assign cfg_err   = cfg_err_q;

`ifdef FDIV_DUTY_EN
   // High while cnt >= floor(L/2): that is the first ceil(L/2) cycles of the period
   logic [CW-1:0] half_q, half_d;
   logic          sq_q;
   logic [CW:0]   m_plus1;

   assign m_plus1 = {1'b0, eff_m} + 1'b1;

   always_comb begin
      half_d = half_q;
      if (start) begin
         half_d = is_long ? m_plus1[CW:1] : {1'b0, eff_m[CW-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         half_q <= '0;
         sq_q   <= 1'b0;
      end else begin
         half_q <= half_d;
         sq_q   <= (state_d == RUN) && (cnt_d >= half_d);
      end
   end

   assign clk_div_sq = sq_q;
`endif

endmodule
